// File: rtl/uart_tx_unit.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_unit
// Brief    : FIFO-buffered 8N1 UART transmitter paced by a 16x oversampling tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_unit #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int FIFO_W  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_tick,
   input  logic       wr_uart,
   input  logic [7:0] w_data,
   output logic       tx,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_done_tick
);

   localparam int DEPTH = 2 ** FIFO_W;
   localparam int S_W   = 5;
   localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [S_W-1:0] c_s_bit_last  = S_W'(15);
   localparam logic [S_W-1:0] c_s_stop_last = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] c_n_last      = N_W'(DBIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Transmit FIFO
   // ------------------------------------------------------------------
   logic [DBIT-1:0]   mem_q [DEPTH];
   logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;

   state_t            state_q;
   logic              w_push;
   logic              w_pop;

   assign w_push = wr_uart & ~full_q;
   assign w_pop  = (state_q == ST_IDLE) & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      full_d   = full_q;
      empty_d  = empty_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + FIFO_W'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_W'(1);
      end
      // A simultaneous push and pop leaves the occupancy, and so the flags, unchanged.
      if (w_push && !w_pop) begin
         empty_d = 1'b0;
         full_d  = (wr_ptr_d == rd_ptr_q);
      end else if (w_pop && !w_push) begin
         full_d  = 1'b0;
         empty_d = (rd_ptr_d == wr_ptr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= w_data[DBIT-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // ------------------------------------------------------------------
   // Frame serialiser
   // ------------------------------------------------------------------
   logic [S_W-1:0]  s_q;
   logic [N_W-1:0]  n_q;
   logic [DBIT-1:0] b_q;
   logic            tx_q;
   logic            busy_q;
   logic            done_q;
   logic [DBIT-1:0] w_b_shr;

   assign w_b_shr = b_q >> 1;

   // tx is loaded with the level of the state being entered so it stays a pure flop output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (!empty_q) begin
                  b_q     <= mem_q[rd_ptr_q];
                  s_q     <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (s_tick) begin
                  if (s_q == c_s_bit_last) begin
                     s_q     <= '0;
                     n_q     <= '0;
                     tx_q    <= b_q[0];
                     state_q <= ST_DATA;
                  end else begin
                     s_q <= s_q + S_W'(1);
                  end
               end
            end
            ST_DATA: begin
               if (s_tick) begin
                  if (s_q == c_s_bit_last) begin
                     s_q <= '0;
                     b_q <= w_b_shr;
                     if (n_q == c_n_last) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end else begin
                        n_q  <= n_q + N_W'(1);
                        tx_q <= w_b_shr[0];
                     end
                  end else begin
                     s_q <= s_q + S_W'(1);
                  end
               end
            end
            ST_STOP: begin
               if (s_tick) begin
                  if (s_q == c_s_stop_last) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     tx_q    <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     s_q <= s_q + S_W'(1);
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx           = tx_q;
   assign tx_full      = full_q;
   assign tx_empty     = empty_q;
   assign tx_busy      = busy_q;
   assign tx_done_tick = done_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_unit.md
# uart_tx_unit

Buffered UART transmitter: accepts byte write strobes (`wr_uart`/`w_data`) from the button-driven data stage, queues them in a small FIFO and serialises each byte as an 8N1 frame on `tx`. Bit timing comes from an external oversampling tick (`s_tick`, 16× baud) generated by the shared baud-rate generator. It sits between the data-producing logic and the board's UART TX pin.

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: `s_tick` count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `FIFO_W`, 2: FIFO address width; depth = 2**FIFO_W (default 4).

- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `s_tick` input 1: single-cycle pulse at 16× baud rate.
- `wr_uart` input 1: write strobe; pushes `w_data` into FIFO when not full.
- `w_data` input 8: byte to transmit (bits above `DBIT-1` ignored).
- `tx` output 1: serial line, idle high, registered.
- `tx_full` output 1: FIFO full.
- `tx_empty` output 1: FIFO empty.
- `tx_busy` output 1: FSM not in IDLE.
- `tx_done_tick` output 1: one-cycle pulse when a stop bit completes.

## Operation
- **Reset values:** `tx`=1, `tx_full`=0, `tx_empty`=1, `tx_busy`=0, `tx_done_tick`=0. FIFO pointers cleared, FSM in IDLE, tick counter `s`=0, bit counter `n`=0.
- **FIFO**
  - Circular buffer with read/write pointers of `FIFO_W` bits; full/empty flags are registered.
  - Push when `wr_uart`=1 and not full.
  - **Write while full:** dropped, even if a pop happens in the same cycle. No overwrite, no error flag.
  - **Simultaneous push and pop when non-empty:** both pointers advance and the flags are unchanged.
  - Pointers wrap modulo depth.
- **FSM (IDLE, START, DATA, STOP)**
  - **IDLE:** `tx`=1. If FIFO not empty: pop head into shift register `b`, set `s`=0, go to START. `s_tick` is ignored.
  - **START:** `tx`=0. On `s_tick`: if `s`=15, then `s`=0, `n`=0, go to DATA; else `s`++.
  - **DATA:** `tx`=`b[0]`. On `s_tick` with `s`=15: `s`=0 and `b` shifts right. If `n`=`DBIT-1`, go to STOP; else `n`++. On any other `s_tick`, `s`++.
  - **STOP:** `tx`=1. On `s_tick` with `s`=`SB_TICK-1`: assert `tx_done_tick` for one cycle and go to IDLE. Otherwise `s`++.
- **Back-to-back frames:** if the FIFO is non-empty on return to IDLE, the next pop happens in the following cycle. The line is high for at most one clock between the stop bit and the next start bit.
- **Counter widths:** `s` is 5 bits (must hold `SB_TICK-1`), `n` is 3 bits (`clog2(DBIT)`).
- **Reset mid-frame:** the frame is abandoned, `tx` returns to 1 at the next edge and FIFO contents are discarded.

## Timing
- Write accepted at edge E0, so `tx_empty` falls after E0.
- At E1 the FSM pops and enters START, so `tx` is low after E1: one clock after the write edge.
- Frame length in `s_tick` pulses: 16 (start) + 16·`DBIT` + `SB_TICK`. With defaults this is 160 ticks.
- `tx_done_tick` is high for exactly the one cycle following the final stop-bit `s_tick` edge. `tx_busy` falls on the same edge.
- `tx` changes only on clock edges and has no combinational path from inputs.

## Test plan
- **Reset:** hold `rst` 3 cycles → `tx`=1, `tx_empty`=1, `tx_full`=0, `tx_busy`=0, `tx_done_tick`=0.
- **Single byte:** write 0x35 with `s_tick` every 4 clocks.
  - `tx` low one clock after the write, then bits 1,0,1,0,1,1,0,0 (LSB first), each 16 ticks wide.
  - Stop bit high for 16 ticks; a single `tx_done_tick`; 160 ticks total.
- **FIFO fill:** with `s_tick` held low, write 0x01..0x05 on consecutive cycles.
  - First byte pops immediately; 0x02..0x05 fill the FIFO and `tx_full`=1.
  - A sixth write of 0x06 is dropped.
  - Enabling `s_tick` yields frames 0x01..0x05 in order and 0x06 never appears.
- **Back-to-back frames:** two bytes queued → a single clock of `tx`=1 between the end of stop bit 1 and start bit 2; two `tx_done_tick` pulses.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with 2 bytes queued → `tx`=1 next edge, `tx_empty`=1, and no further frames after release.
- **Stop-bit variant:** `SB_TICK`=32, byte 0xFF → stop interval 32 ticks, frame 176 ticks.
